count_capture_fifo: RTL

Downstream consumer of the free-running up-counter. Tracks the counter's raw CW-bit output and extends it with a wrap-count field. Detects sequence breaks, such as an upstream reset mid-count. On a capture strobe, it stores the extended value into a small FIFO that is drained over a valid/ready interface.

---
 rtl/count_capture_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - counter tracker with wrap extension and capture FIFO
//
// Follows a free-running up-counter, extends its value with a wrap count,
// flags sequence breaks, and queues captured extended values in a small FIFO
// drained over a valid/ready interface.
//
// Optional feature macro: CCF_AUTO_CAP_EN
//   defined   - every counter wrap cycle also pushes the extended value
//   undefined - entries are pushed only by cap
//
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   cnt_in   in   [CW-1:0] upstream counter value
//   cap      in   capture strobe, one entry per asserted cycle
//   clr_err  in   clears sticky seq_err and ovf (a same-cycle set wins)
//   o_valid  out  FIFO head valid
//   o_ready  in   consumer ready
//   o_data   out  [EW+CW-1:0] FIFO head, {wrap, cnt}
//   level    out  [$clog2(DEPTH):0] FIFO occupancy
//   seq_err  out  sticky counter sequence break
//   ovf      out  sticky capture dropped on full FIFO

module count_capture_fifo #(
  parameter int CW    = 4,
  parameter int EW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [CW-1:0]            cnt_in,
  input  logic                     cap,
  input  logic                     clr_err,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [EW+CW-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seq_err,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = EW + CW;

  logic [CW-1:0] r_prev_cnt;
  logic          r_prev_vld;
  logic [EW-1:0] r_wrap_cnt;
  logic          r_seq_err;
  logic          r_ovf;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic [CW-1:0] w_prev_inc;
  logic          w_prev_max;
  logic          w_is_hold;
  logic          w_is_step;
  logic          w_is_wrap;
  logic          w_is_break;
  logic [EW-1:0] w_wrap_next;
  logic [DW-1:0] w_ext;
  logic          w_push_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Transition classification; nothing is checked on the first cycle after
  // reset because prev_cnt has not been loaded yet.
  assign w_prev_inc = r_prev_cnt + CW'(1);
  assign w_prev_max = &r_prev_cnt;
  assign w_is_hold  = (cnt_in == r_prev_cnt);
  assign w_is_step  = !w_prev_max && (cnt_in == w_prev_inc);
  assign w_is_wrap  = r_prev_vld && w_prev_max && (cnt_in == '0);
  assign w_is_break = r_prev_vld && !(w_is_hold || w_is_step || w_is_wrap);

  assign w_wrap_next = w_is_break ? '0 :
                       w_is_wrap  ? r_wrap_cnt + EW'(1) :
                                    r_wrap_cnt;

  // Captured value carries the wrap count as updated in this same cycle.
  assign w_ext = {w_wrap_next, cnt_in};

`ifdef CCF_AUTO_CAP_EN
  assign w_push_req = cap | w_is_wrap;
`else
  assign w_push_req = cap;
`endif

  assign o_valid = (r_level != '0);
  assign w_full  = (r_level == (AW+1)'(DEPTH));
  assign w_pop   = o_valid & o_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle;
  // the freed slot is the one the write pointer already addresses.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_prev_cnt <= '0;
      r_prev_vld <= 1'b0;
      r_wrap_cnt <= '0;
      r_seq_err  <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      // Storage is cleared so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_prev_cnt <= cnt_in;
      r_prev_vld <= 1'b1;
      r_wrap_cnt <= w_wrap_next;
      r_seq_err  <= w_is_break | (r_seq_err & ~clr_err);
      r_ovf      <= w_drop | (r_ovf & ~clr_err);

      if (w_push) begin
        r_mem[r_wr_ptr] <= w_ext;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign level   = r_level;
  assign seq_err = r_seq_err;
  assign ovf     = r_ovf;

endmodule
